logic_cluster_n: RTL and testbench
==================================

// Module: logic_cluster_n
// PURPOSE
// Parametrised successor of the single logic cell: NUM_CELLS LUT+flop cells with a
// ripple carry chain and an on-block configuration loader. LUT contents and per-cell
// modes load as CFG_W-bit beats over a valid/ready handshake; cells run only once
// fully configured. Sits in the logic tile between the routing muxes and the cluster outputs.
// PARAMETERS
// NUM_CELLS  4  number of logic cells (>=1)
// LUT_K      4  LUT inputs per cell (2..6); LUT init = 2**LUT_K bits
// CFG_W      8  config beat width (>=1)
// Derived: CELL_CFG_W=2**LUT_K+3; CFG_BITS=NUM_CELLS*CELL_CFG_W; NBEATS=ceil(CFG_BITS/CFG_W)
// PORTS
// QCK        in   1                 clock, all state on rising edge
// QRT        in   1                 reset, synchronous, active-high
// cfg_start  in   1                 request (re)configuration
// cfg_valid  in   1                 cfg_data beat valid
// cfg_data   in   CFG_W             config beat
// cfg_ready  out  1                 loader accepts beats (state LOAD)
// cfg_done   out  1                 configuration complete, cells active (state ACTIVE)
// LI         in   NUM_CELLS*LUT_K   LUT inputs; cell c = LI[c*LUT_K +: LUT_K], bit0 = I0
// QDI        in   NUM_CELLS         direct flop data per cell
// QEN        in   NUM_CELLS         flop enable per cell
// QST        in   NUM_CELLS         synchronous set per cell
// CI         in   1                 carry into cell 0
// FZ         out  NUM_CELLS         combinational LUT outputs
// AQZ        out  NUM_CELLS         registered outputs
// CO         out  1                 carry out of cell NUM_CELLS-1
// BEHAVIOUR
// - Reset (QRT=1 at edge): state IDLE, cfg register all 0, beat counter 0, AQZ=0.
//   Outputs after reset: cfg_ready=0, cfg_done=0, FZ=0, CO=0. QRT overrides all else, incl. mid-load.
// - FSM: IDLE --cfg_start--> LOAD; LOAD --NBEATS-th accepted beat--> ACTIVE;
//   ACTIVE --cfg_start--> LOAD. cfg_start in LOAD ignored (load continues).
// - Entering LOAD: beat counter=0, cfg register cleared to 0, AQZ cleared to 0.
// - Beat accepted iff cfg_valid & cfg_ready at edge; beat i written to cfg bits
//   [i*CFG_W +: CFG_W]; bits >= CFG_BITS discarded. cfg_valid outside LOAD ignored.
// - cfg_done=1 from the edge accepting beat NBEATS-1; cfg_ready=0 same edge.
// - Cell c config word W=cfg[c*CELL_CFG_W +: CELL_CFG_W]: W[2**K-1:0] LUT init;
//   W[2**K]=CDS (1: flop D=LUT out, 0: D=QDI[c]); W[2**K+1]=CARRY_EN;
//   W[2**K+2]=QEN_USE (0: flop always enabled).
// - LUT: FZ[c]=INIT[idx], idx=cell inputs as unsigned {I(K-1)..I0}. If CARRY_EN,
//   I2 is replaced by carry-in ci[c] before lookup (needs LUT_K>=3; else ignored).
// - Carry: ci[0]=CI; co[c]=CARRY_EN ? (I0&I1)|(ci[c]&(I0^I1)) : ci[c] (pass-through);
//   ci[c+1]=co[c]; CO=co[NUM_CELLS-1]. Purely combinational ripple.
// - Outside ACTIVE: FZ=0, CO=0, AQZ held at 0; QST/QEN/QDI ignored.
// - Flop in ACTIVE, per cell, priority: QST[c]=1 -> AQZ=1; else if (!QEN_USE | QEN[c])
//   -> AQZ=D; else hold. Latency: D to AQZ one edge; FZ zero cycles.
// TESTING (NUM_CELLS=2, LUT_K=4, CFG_W=8 -> CELL_CFG_W=19, CFG_BITS=38, NBEATS=5)
// 1 QRT=1 one edge, all other inputs toggling -> AQZ=0,FZ=0,CO=0,cfg_ready=0,cfg_done=0.
// 2 cfg_start; 5 beats, cell0 INIT=16'h8000, CDS=1, QEN_USE=0 -> cfg_done=1 on 5th
//   beat edge; LI[3:0]=4'hF -> FZ[0]=1 same cycle, AQZ[0]=1 next edge; LI=4'hE -> FZ[0]=0.
// 3 both cells INIT=16'h9696, CARRY_EN=1; CI=1, cell0 I0=1,I1=0, cell1 I0=1,I1=1
//   -> FZ=2'b10, co0=1, CO=1; CI=0 -> FZ=2'b01, CO=1.
// 4 QEN_USE=1: QEN=0 -> AQZ holds across 3 edges; QST=1 with QEN=0 -> AQZ=1 next edge.
// 5 QRT=1 after beat 3 of a load -> IDLE, cfg_done=0; new cfg_start needs all 5 beats
//   (cfg_done stays 0 after 4).
// 6 cfg_valid pulses in IDLE -> no effect; cfg_start in ACTIVE with AQZ=1 -> next edge
//   AQZ=0, cfg_done=0, cfg_ready=1, FZ=0.

Source files
------------

// File: rtl/logic_cluster_n.sv
// Logic cluster: NUM_CELLS LUT+flop cells with a ripple carry chain and a
// beat-wise configuration loader. Cells only drive outputs once fully configured.
module logic_cluster_cell #(
   parameter int LUT_K = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clr_i,
   input  logic                active_i,
   input  logic [2**LUT_K+2:0] cfg_i,
   input  logic [LUT_K-1:0]    li_i,
   input  logic                qdi_i,
   input  logic                qen_i,
   input  logic                qst_i,
   input  logic                ci_i,
   output logic                fz_o,
   output logic                co_o,
   output logic                aqz_o
);
   localparam int INIT_W = 2**LUT_K;

   logic [INIT_W-1:0] init;
   logic              cds, carry_en, qen_use, lut, aqz_q;
   logic [LUT_K-1:0]  idx;

   assign init     = cfg_i[INIT_W-1:0];
   assign cds      = cfg_i[INIT_W];
   assign carry_en = cfg_i[INIT_W+1];
   assign qen_use  = cfg_i[INIT_W+2];

   // Carry-in steals the I2 input; narrower LUTs have no I2 to steal.
   if (LUT_K >= 3) begin : g_ci
      always_comb begin
         idx = li_i;
         if (carry_en) idx[2] = ci_i;
      end
   end else begin : g_noci
      assign idx = li_i;
   end

   assign lut   = init[idx];
   assign fz_o  = active_i & lut;
   assign co_o  = carry_en ? ((li_i[0] & li_i[1]) | (ci_i & (li_i[0] ^ li_i[1]))) : ci_i;
   assign aqz_o = aqz_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i)          aqz_q <= 1'b0;
      else if (qst_i)              aqz_q <= 1'b1;
      else if (!qen_use || qen_i)  aqz_q <= cds ? lut : qdi_i;
   end
endmodule

module logic_cluster_n #(
   parameter int NUM_CELLS = 4,
   parameter int LUT_K     = 4,
   parameter int CFG_W     = 8
) (
   input  logic                         QCK,
   input  logic                         QRT,
   input  logic                         cfg_start,
   input  logic                         cfg_valid,
   input  logic [CFG_W-1:0]             cfg_data,
   output logic                         cfg_ready,
   output logic                         cfg_done,
   input  logic [NUM_CELLS*LUT_K-1:0]   LI,
   input  logic [NUM_CELLS-1:0]         QDI,
   input  logic [NUM_CELLS-1:0]         QEN,
   input  logic [NUM_CELLS-1:0]         QST,
   input  logic                         CI,
   output logic [NUM_CELLS-1:0]         FZ,
   output logic [NUM_CELLS-1:0]         AQZ,
   output logic                         CO
);
   localparam int CELL_CFG_W = 2**LUT_K + 3;
   localparam int CFG_BITS   = NUM_CELLS * CELL_CFG_W;
   localparam int NBEATS     = (CFG_BITS + CFG_W - 1) / CFG_W;
   localparam int CNT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACTIVE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CFG_BITS-1:0] cfg_q, cfg_d, wr_cfg;
   logic [NUM_CELLS:0]  carry;
   logic                active, clr;

   // Beat b overwrites its slice; the final beat's slice is clipped to CFG_BITS.
   for (genvar b = 0; b < NBEATS; b++) begin : g_beat
      localparam int LO = b * CFG_W;
      localparam int HI = (LO + CFG_W > CFG_BITS) ? CFG_BITS : LO + CFG_W;
      assign wr_cfg[HI-1:LO] = (cnt_q == CNT_W'(b)) ? cfg_data[HI-LO-1:0] : cfg_q[HI-1:LO];
   end

   always_ff @(posedge QCK) begin
      if (QRT) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cfg_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cfg_q   <= cfg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cfg_d   = cfg_q;
      case (state_q)
         S_IDLE, S_ACTIVE: if (cfg_start) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            cfg_d   = '0;
         end
         S_LOAD: if (cfg_valid) begin
            cfg_d = wr_cfg;
            if (cnt_q == CNT_W'(NBEATS - 1)) begin
               state_d = S_ACTIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign active    = (state_q == S_ACTIVE);
   assign clr       = !active || cfg_start;
   assign cfg_ready = (state_q == S_LOAD);
   assign cfg_done  = active;
   assign carry[0]  = CI;
   assign CO        = active & carry[NUM_CELLS];

   for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
      logic_cluster_cell #(.LUT_K(LUT_K)) u_cell (
         .clk_i    (QCK),
         .rst_i    (QRT),
         .clr_i    (clr),
         .active_i (active),
         .cfg_i    (cfg_q[c*CELL_CFG_W +: CELL_CFG_W]),
         .li_i     (LI[c*LUT_K +: LUT_K]),
         .qdi_i    (QDI[c]),
         .qen_i    (QEN[c]),
         .qst_i    (QST[c]),
         .ci_i     (carry[c]),
         .fz_o     (FZ[c]),
         .co_o     (carry[c+1]),
         .aqz_o    (AQZ[c])
      );
   end
endmodule

// File: tb/tb_logic_cluster_n.sv
// Bench for logic_cluster_n (2 cells, 4-LUT, 8-bit beats): expected status words
// are queued when stimulus is driven and popped when the outputs are sampled.
module tb_logic_cluster_n;
   logic       QCK = 1'b0;
   logic       QRT, cfg_start, cfg_valid, CI;
   logic [7:0] cfg_data, LI;
   logic [1:0] QDI, QEN, QST, FZ, AQZ;
   logic       cfg_ready, cfg_done, CO;

   int checks = 0;
   int errors = 0;
   logic [6:0] exp_q[$];
   logic [6:0] exp;
   wire  [6:0] status = {cfg_ready, cfg_done, CO, FZ, AQZ};

   logic_cluster_n #(.NUM_CELLS(2), .LUT_K(4), .CFG_W(8)) dut (
      .QCK(QCK), .QRT(QRT), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
      .cfg_data(cfg_data), .cfg_ready(cfg_ready), .cfg_done(cfg_done),
      .LI(LI), .QDI(QDI), .QEN(QEN), .QST(QST), .CI(CI),
      .FZ(FZ), .AQZ(AQZ), .CO(CO)
   );

   always #5 QCK = ~QCK;

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   function automatic logic [18:0] mkw(input logic [15:0] init, input logic cds,
                                       input logic carry, input logic qenuse);
      return {qenuse, carry, cds, init};
   endfunction

   // Reference: {CO, FZ[1:0]} for an active cluster.
   function automatic logic [2:0] model(input logic [39:0] cfg, input logic [7:0] li,
                                        input logic ci);
      logic c; logic [18:0] w; logic [3:0] i, idx; logic [1:0] fz;
      c = ci; fz = 2'b00;
      for (int n = 0; n < 2; n++) begin
         w = cfg[n*19 +: 19];
         i = li[n*4 +: 4];
         idx = i;
         if (w[17]) idx[2] = c;
         fz[n] = w[idx];
         c = w[17] ? ((i[0] & i[1]) | (c & (i[0] ^ i[1]))) : c;
      end
      return {c, fz};
   endfunction

   task automatic edge_t();
      @(posedge QCK); #1;
   endtask

   task automatic idle_inputs();
      QRT = 0; cfg_start = 0; cfg_valid = 0; cfg_data = 0;
      LI = 0; QDI = 0; QEN = 0; QST = 0; CI = 0;
   endtask

   task automatic load_cfg(input logic [39:0] bits);
      cfg_start = 1; edge_t(); cfg_start = 0;
      for (int b = 0; b < 5; b++) begin
         cfg_valid = 1; cfg_data = bits[b*8 +: 8]; edge_t();
      end
      cfg_valid = 0;
   endtask

   task automatic test_reset();
      QRT = 1; cfg_start = 1; cfg_valid = 1; cfg_data = 8'hA5;
      LI = 8'hFF; QDI = 2'b11; QEN = 2'b11; QST = 2'b11; CI = 1;
      edge_t();
      LI = 8'h5A; QST = 2'b01; CI = 0; cfg_data = 8'h3C;
      exp_q.push_back(7'b0);
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL reset_outputs got %b exp %b", status, exp); end
      idle_inputs(); edge_t();
      exp_q.push_back(7'b0);
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL idle_after_reset got %b exp %b", status, exp); end
   endtask

   task automatic test_lut();
      logic [39:0] bits;
      bits = {2'b00, 19'h0, mkw(16'h8000, 1, 0, 0)};
      LI = 8'hFF; CI = 1;
      cfg_start = 1; edge_t(); cfg_start = 0;
      for (int b = 0; b < 5; b++) begin
         cfg_valid = 1; cfg_data = bits[b*8 +: 8];
         exp_q.push_back(b < 4 ? 7'b1000000 : {2'b01, model(bits, LI, CI), 2'b00});
         edge_t();
         #1; exp = exp_q.pop_front(); checks++;
         if (status !== exp) begin errors++; $display("FAIL load_beat%0d got %b exp %b", b, status, exp); end
      end
      cfg_valid = 0; LI = 8'h0F; CI = 0;
      exp_q.push_back(7'b0100100);
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL fz_same_cycle got %b exp %b", status, exp); end
      edge_t();
      exp_q.push_back(7'b0100101);
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL aqz_next_edge got %b exp %b", status, exp); end
      LI = 8'h0E;
      exp_q.push_back(7'b0100001);
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL fz_low got %b exp %b", status, exp); end
      QDI = 2'b10; edge_t();
      exp_q.push_back(7'b0100010);
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL qdi_path got %b exp %b", status, exp); end
      QDI = 2'b00;
   endtask

   task automatic test_carry();
      logic [39:0] bits;
      bits = {2'b00, mkw(16'h9696, 0, 1, 0), mkw(16'h9696, 0, 1, 0)};
      load_cfg(bits);
      CI = 1; LI = 8'h31;
      exp_q.push_back(7'b0111000);
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL carry_ci1 got %b exp %b", status, exp); end
      CI = 0;
      exp_q.push_back(7'b0110100);
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL carry_ci0 got %b exp %b", status, exp); end
      for (int n = 0; n < 8; n++) begin
         LI = 8'($urandom); CI = 1'($urandom);
         exp_q.push_back({2'b01, model(bits, LI, CI), 2'b00});
         #1; exp = exp_q.pop_front(); checks++;
         if (status !== exp) begin errors++; $display("FAIL carry_rand li=%h ci=%b got %b exp %b", LI, CI, status, exp); end
         #1;
      end
      LI = 0; CI = 0;
   endtask

   task automatic test_enable();
      logic [39:0] bits;
      logic [1:0]  qen_t[5], qdi_t[5], qst_t[5], aqz_t[5];
      bits = {2'b00, mkw(16'h0000, 0, 0, 1), mkw(16'h0000, 0, 0, 1)};
      load_cfg(bits);
      // rows: load 11, hold x3 with QEN=0, load 00, QST over QEN=0, QST over QEN=1/QDI=0
      qen_t = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
      qdi_t = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
      qst_t = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      aqz_t = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
      for (int n = 0; n < 5; n++) begin
         QEN = qen_t[n]; QDI = qdi_t[n]; QST = qst_t[n];
         exp_q.push_back({5'b01000, aqz_t[n]});
         edge_t();
         #1; exp = exp_q.pop_front(); checks++;
         if (status !== exp) begin errors++; $display("FAIL qen_step%0d got %b exp %b", n, status, exp); end
      end
      QEN = 2'b00; QDI = 2'b00; QST = 2'b01;
      exp_q.push_back(7'b0100001);
      edge_t();
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL qst_over_qen got %b exp %b", status, exp); end
      QEN = 2'b10; QST = 2'b10;
      exp_q.push_back(7'b0100011);
      edge_t();
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL qst_priority got %b exp %b", status, exp); end
      QEN = 0; QST = 0;
   endtask

   task automatic test_midload_reset();
      logic [39:0] bits;
      bits = {2'b00, 19'h0, mkw(16'hFFFF, 0, 0, 0)};
      cfg_start = 1; edge_t(); cfg_start = 0;
      for (int b = 0; b < 3; b++) begin
         cfg_valid = 1; cfg_data = bits[b*8 +: 8]; edge_t();
      end
      QRT = 1; cfg_data = bits[24 +: 8];
      exp_q.push_back(7'b0);
      edge_t(); QRT = 0; cfg_valid = 0;
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL midload_reset got %b exp %b", status, exp); end
      CI = 1; LI = 8'h00;
      cfg_start = 1; edge_t(); cfg_start = 0;
      for (int b = 0; b < 4; b++) begin
         cfg_valid = 1; cfg_data = bits[b*8 +: 8]; edge_t();
      end
      exp_q.push_back(7'b1000000);
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL after_4_beats got %b exp %b", status, exp); end
      cfg_data = bits[32 +: 8];
      exp_q.push_back({2'b01, model(bits, LI, CI), 2'b00});
      edge_t(); cfg_valid = 0;
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL fifth_beat got %b exp %b", status, exp); end
      CI = 0;
   endtask

   task automatic test_back_to_back();
      logic [39:0] bits;
      bits = {2'b00, 19'h0, mkw(16'h8000, 1, 0, 0)};
      QRT = 1; edge_t(); QRT = 0;
      cfg_data = 8'h5A;
      for (int n = 0; n < 3; n++) begin
         cfg_valid = 1; exp_q.push_back(7'b0);
         edge_t();
         #1; exp = exp_q.pop_front(); checks++;
         if (status !== exp) begin errors++; $display("FAIL idle_valid%0d got %b exp %b", n, status, exp); end
      end
      cfg_valid = 0; LI = 8'h0F; CI = 1;
      cfg_start = 1; edge_t(); cfg_start = 0;
      for (int b = 0; b < 5; b++) begin
         cfg_valid = 1; cfg_data = bits[b*8 +: 8];
         cfg_start = (b == 2);
         edge_t();
      end
      cfg_valid = 0; cfg_start = 0;
      exp_q.push_back({2'b01, model(bits, LI, CI), 2'b00});
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL start_in_load got %b exp %b", status, exp); end
      exp_q.push_back({2'b01, model(bits, LI, CI), 2'b01});
      edge_t();
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL aqz_before_reload got %b exp %b", status, exp); end
      cfg_start = 1;
      exp_q.push_back(7'b1000000);
      edge_t(); cfg_start = 0;
      #1; exp = exp_q.pop_front(); checks++;
      if (status !== exp) begin errors++; $display("FAIL reconfig_clear got %b exp %b", status, exp); end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_lut();
      test_carry();
      test_enable();
      test_midload_reset();
      test_back_to_back();
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
